t10_uart_rx_frame_ctrl: RTL and testbench

Frame-level controller for the team's UART receive path. It gates the byte receiver with `rec_ready` and detects each received byte. It parses the frame `SYNC, LEN, PAYLOAD[LEN], CSUM`, writes payload bytes into an external frame buffer, and hands each complete frame to the consumer with a valid/ack handshake. It sits between the UART byte receiver and the command decoder, and reports malformed, corrupted and stalled frames.

---
 rtl/t10_uart_rx_frame_ctrl_pkg.sv | 28 ++
 rtl/t10_uart_rx_frame_ctrl_if.sv | 33 +++
 rtl/t10_uart_rx_frame_ctrl.sv | 174 +++++++++++++++++
 tb/tb_t10_uart_rx_frame_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t10_uart_rx_frame_ctrl_pkg.sv
// Shared types for the UART receive frame controller.
// Holds the parser state enum, the abort cause enum, the default frame start marker
// and a helper that sizes the frame buffer address.
package t10_uart_pkg;

  localparam logic [7:0] SyncByteDefault = 8'hA5;

  typedef enum logic [2:0] {
    StHunt,
    StLen,
    StData,
    StCsum,
    StHold
  } state_e;

  typedef enum logic [1:0] {
    ErrNone    = 2'd0,
    ErrLen     = 2'd1,
    ErrCsum    = 2'd2,
    ErrTimeout = 2'd3
  } err_e;

  // A one-entry buffer still needs a one-bit address.
  function automatic int unsigned addr_width(input int unsigned max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

endpackage

// File: rtl/t10_uart_rx_frame_ctrl_if.sv
// Bus between the frame controller and its environment.
// master: the controller (consumes rx_ready/rx_byte/frame_ack, drives everything else).
// slave : byte receiver + frame buffer + consumer side.
interface t10_uart_rx_frame_ctrl_if #(
  parameter int unsigned MAX_LEN = 16
);
  localparam int unsigned AW = t10_uart_pkg::addr_width(MAX_LEN);

  logic          rx_ready;
  logic [7:0]    rx_byte;
  logic          frame_ack;
  logic          rec_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          frame_valid;
  logic [7:0]    frame_len;
  logic          frame_err;
  logic [1:0]    err_code;
  logic [7:0]    err_count;

  modport master (
    input  rx_ready, rx_byte, frame_ack,
    output rec_ready, wr_en, wr_addr, wr_data, frame_valid, frame_len,
           frame_err, err_code, err_count
  );

  modport slave (
    output rx_ready, rx_byte, frame_ack,
    input  rec_ready, wr_en, wr_addr, wr_data, frame_valid, frame_len,
           frame_err, err_code, err_count
  );
endinterface

// File: rtl/t10_uart_rx_frame_ctrl.sv
// Frame-level controller for the UART receive path.
// Parses SYNC, LEN, PAYLOAD[LEN], CSUM from the byte receiver, writes payload into an
// external buffer, presents complete frames with a valid/ack handshake and reports
// bad-length, checksum and inter-byte timeout aborts.
// Ports: clk, nRst (async, active-low), bus (master modport, see the interface file).
module t10_uart_rx_frame_ctrl
  import t10_uart_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SyncByteDefault,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 12000
) (
  input logic                       clk,
  input logic                       nRst,
  t10_uart_rx_frame_ctrl_if.master  bus
);

  localparam int unsigned   AW      = addr_width(MAX_LEN);
  localparam int unsigned   TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic          rx_ready_q;
  logic [7:0]    len_q, len_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          rec_ready_q, rec_ready_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [7:0]    err_count_q, err_count_d;

  logic byte_evt;
  logic in_frame;
  logic abort;
  err_e abort_code;

  // Only the rising edge of rx_ready carries a valid byte.
  assign byte_evt = bus.rx_ready & ~rx_ready_q;
  assign in_frame = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    csum_d      = csum_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    err_count_d = err_count_q;
    abort       = 1'b0;
    abort_code  = ErrNone;

    unique case (state_q)
      StHunt: begin
        if (byte_evt && bus.rx_byte == SYNC_BYTE) begin
          state_d    = StLen;
          err_code_d = ErrNone;
        end
      end
      StLen: begin
        if (byte_evt) begin
          if (bus.rx_byte == 8'd0 || 32'(bus.rx_byte) > MAX_LEN) begin
            abort      = 1'b1;
            abort_code = ErrLen;
          end else begin
            len_d   = bus.rx_byte;
            csum_d  = bus.rx_byte;
            idx_d   = 8'd0;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (byte_evt) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q[AW-1:0];
          wr_data_d = bus.rx_byte;
          csum_d    = csum_q + bus.rx_byte;
          idx_d     = idx_q + 8'd1;
          if (idx_q + 8'd1 == len_q) state_d = StCsum;
        end
      end
      StCsum: begin
        if (byte_evt) begin
          if (bus.rx_byte == csum_q) begin
            state_d = StHold;
          end else begin
            abort      = 1'b1;
            abort_code = ErrCsum;
          end
        end
      end
      StHold: begin
        if (bus.frame_ack) state_d = StHunt;
      end
      default: state_d = StHunt;
    endcase

    // A byte event in the same cycle as expiry wins and restarts the count.
    if (byte_evt) begin
      tmo_d = '0;
    end else if (in_frame) begin
      if (tmo_q == TmoLast) begin
        abort      = 1'b1;
        abort_code = ErrTimeout;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    if (abort) begin
      state_d    = StHunt;
      err_d      = 1'b1;
      err_code_d = abort_code;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end

    rec_ready_d = (state_d != StHold);
    valid_d     = (state_d == StHold);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= StHunt;
      rx_ready_q  <= 1'b0;
      len_q       <= 8'd0;
      csum_q      <= 8'd0;
      idx_q       <= 8'd0;
      tmo_q       <= '0;
      rec_ready_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'd0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      rx_ready_q  <= bus.rx_ready;
      len_q       <= len_d;
      csum_q      <= csum_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      rec_ready_q <= rec_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.rec_ready   = rec_ready_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.frame_valid = valid_q;
  assign bus.frame_len   = len_q;
  assign bus.frame_err   = err_q;
  assign bus.err_code    = err_code_q;
  assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_t10_uart_rx_frame_ctrl.sv
// Scoreboard bench for t10_uart_rx_frame_ctrl: a stream-level frame parser predicts
// buffer writes, frames and aborts; a monitor pops and compares as the DUT shows them.
module tb_t10_uart_rx_frame_ctrl;

  localparam logic [7:0]  Sync    = 8'hA5;
  localparam int unsigned MaxLen  = 16;
  localparam int unsigned Timeout = 12000;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic nRst = 1'b0;
  always #5 clk = ~clk;

  t10_uart_rx_frame_ctrl_if #(.MAX_LEN(MaxLen)) bus ();

  t10_uart_rx_frame_ctrl #(
    .SYNC_BYTE      (Sync),
    .MAX_LEN        (MaxLen),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_errs = 0;

  logic [15:0] wq[$];  // {addr, data}
  logic [9:0]  eq[$];  // {code, err_count}
  logic [7:0]  fq[$];  // frame_len

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual %0h required none", name, act);
  endtask

  task automatic push_err(input logic [1:0] code);
    if (exp_errs < 255) exp_errs++;
    eq.push_back({code, 8'(exp_errs)});
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_byte  = b;
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_byte = 8'($urandom);  // only the first high cycle carries data
    repeat (2) @(negedge clk);
    bus.rx_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Reference: scan the whole stream as a list of bytes and apply the framing rules.
  task automatic run_stream(input bq_t s, input bit silence, output bit got_frame);
    int i = 0;
    int n = s.size();
    bit partial = 1'b0;
    int len;
    int avail;
    logic [7:0] sum;
    got_frame = 1'b0;
    while (i < n && !got_frame) begin
      if (s[i] != Sync) begin
        i++;
        continue;
      end
      if (i + 1 >= n) begin
        partial = 1'b1;
        break;
      end
      len = int'(s[i+1]);
      if (len == 0 || len > MaxLen) begin
        push_err(2'd1);
        i += 2;
        continue;
      end
      avail = n - (i + 2);
      sum = s[i+1];
      for (int k = 0; k < len && k < avail; k++) begin
        wq.push_back({8'(k), s[i+2+k]});
        sum += s[i+2+k];
      end
      if (avail <= len) begin
        partial = 1'b1;
        break;
      end
      if (s[i+2+len] == sum) begin
        fq.push_back(8'(len));
        got_frame = 1'b1;
      end else begin
        push_err(2'd2);
      end
      i += len + 3;
    end
    if (partial && silence) push_err(2'd3);
    foreach (s[j]) send_byte(s[j]);
    if (silence) repeat (Timeout + 20) @(negedge clk);
    else repeat (4) @(negedge clk);
  endtask

  task automatic do_ack();
    for (int c = 0; c < 50 && !bus.frame_valid; c++) @(negedge clk);
    check("ack_wait_valid", 32'(bus.frame_valid), 32'd1);
    bus.frame_ack = 1'b1;
    @(negedge clk);
    bus.frame_ack = 1'b0;
    check("ack_valid_low", 32'(bus.frame_valid), 32'd0);
    check("ack_rec_ready", 32'(bus.rec_ready), 32'd1);
  endtask

  // Monitor
  initial begin : monitor
    logic prev_valid;
    logic [15:0] w;
    logic [9:0]  e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.wr_en) begin
        if (wq.size() == 0) unexpected("write", {16'd0, 8'(bus.wr_addr), bus.wr_data});
        else begin
          w = wq.pop_front();
          check("write_addr", 32'(bus.wr_addr), 32'(w[15:8]));
          check("write_data", 32'(bus.wr_data), 32'(w[7:0]));
        end
      end
      if (bus.frame_err) begin
        if (eq.size() == 0) unexpected("frame_err", {22'd0, bus.err_code, bus.err_count});
        else begin
          e = eq.pop_front();
          check("err_code", 32'(bus.err_code), 32'(e[9:8]));
          check("err_count", 32'(bus.err_count), 32'(e[7:0]));
          check("err_no_valid", 32'(bus.frame_valid), 32'd0);
        end
      end
      if (bus.frame_valid && !prev_valid) begin
        if (fq.size() == 0) unexpected("frame_valid", 32'(bus.frame_len));
        else begin
          check("frame_len", 32'(bus.frame_len), 32'(fq.pop_front()));
          check("valid_rec_ready", 32'(bus.rec_ready), 32'd0);
        end
      end
      prev_valid = bus.frame_valid;
    end
  end

  initial begin : stim
    bq_t s;
    bit got;
    int kind;
    int len;
    logic [7:0] sum;
    logic [7:0] b;
    bus.rx_ready  = 1'b0;
    bus.rx_byte   = 8'd0;
    bus.frame_ack = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_rec_ready", 32'(bus.rec_ready), 32'd0);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check("rst_frame_len", 32'(bus.frame_len), 32'd0);
    check("rst_err_code", 32'(bus.err_code), 32'd0);
    check("rst_err_count", 32'(bus.err_count), 32'd0);
    nRst = 1'b1;
    @(negedge clk);
    check("rec_ready_after_rst", 32'(bus.rec_ready), 32'd1);

    // Good frame
    s = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
    run_stream(s, 1'b0, got);
    check("good_rec_ready_low", 32'(bus.rec_ready), 32'd0);
    do_ack();

    // Bad checksum
    s = '{8'hA5, 8'h01, 8'h7F, 8'h00};
    run_stream(s, 1'b0, got);
    check("csum_err_code", 32'(bus.err_code), 32'd2);
    check("csum_no_valid", 32'(bus.frame_valid), 32'd0);

    // Bad lengths: zero and MAX_LEN + 1
    s = '{8'hA5, 8'h00, 8'hA5, 8'h11};
    run_stream(s, 1'b0, got);
    check("len_err_code", 32'(bus.err_code), 32'd1);
    check("len_err_count", 32'(bus.err_count), 32'(exp_errs));

    // Timeout mid-frame, then a stray byte in HUNT
    s = '{8'hA5, 8'h03, 8'h01};
    run_stream(s, 1'b1, got);
    s = '{8'h00};
    run_stream(s, 1'b0, got);
    check("tmo_err_code_held", 32'(bus.err_code), 32'd3);

    // Noise before sync, then a byte while holding
    s = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h44, 8'h45};
    run_stream(s, 1'b0, got);
    check("sync_clears_err_code", 32'(bus.err_code), 32'd0);
    send_byte(8'h55);
    check("hold_valid_kept", 32'(bus.frame_valid), 32'd1);
    check("hold_rec_ready", 32'(bus.rec_ready), 32'd0);
    do_ack();

    // Randomized frames
    for (int it = 0; it < 12; it++) begin
      s = {};
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        b = 8'($urandom);
        if (b == Sync) b = 8'h00;
        s.push_back(b);
      end
      kind = int'($urandom_range(0, 3));
      s.push_back(Sync);
      if (kind == 2) begin
        s.push_back(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MaxLen + 1, 255)));
      end else begin
        len = int'($urandom_range(1, MaxLen));
        s.push_back(8'(len));
        sum = 8'(len);
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom);
          s.push_back(b);
          sum += b;
        end
        s.push_back((kind == 1) ? sum + 8'($urandom_range(1, 255)) : sum);
      end
      run_stream(s, 1'b0, got);
      if (got) do_ack();
    end

    // Randomized truncated frame ending in silence
    len = int'($urandom_range(2, MaxLen));
    s = '{Sync};
    s.push_back(8'(len));
    for (int k = 0; k < int'($urandom_range(0, len)); k++) s.push_back(8'($urandom));
    run_stream(s, 1'b1, got);
    check("rand_tmo_err_code", 32'(bus.err_code), 32'd3);

    // Reset in the middle of DATA
    s = '{8'hA5, 8'h04, 8'h01, 8'h02};
    run_stream(s, 1'b0, got);
    @(negedge clk);
    nRst = 1'b0;
    #1;
    exp_errs = 0;
    check("mid_rst_rec_ready", 32'(bus.rec_ready), 32'd0);
    check("mid_rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("mid_rst_frame_len", 32'(bus.frame_len), 32'd0);
    check("mid_rst_err_code", 32'(bus.err_code), 32'd0);
    check("mid_rst_err_count", 32'(bus.err_count), 32'd0);
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);

    // Frame after reset starts cleanly
    s = '{8'hA5, 8'h01, 8'h44, 8'h45};
    run_stream(s, 1'b0, got);
    do_ack();
    check("final_err_count", 32'(bus.err_count), 32'd0);

    repeat (5) @(negedge clk);
    check("writes_drained", 32'(wq.size()), 32'd0);
    check("errors_drained", 32'(eq.size()), 32'd0);
    check("frames_drained", 32'(fq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
